// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; ovf only exists when
// SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, carry FF between bits.
// Optional SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] sha, shb, shr, sum_q;
  logic             carry, cout_q;
  logic [CW-1:0]    cnt;
  logic             s, co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  serial_adder_fa u_fa (.x(sha[0]), .y(shb[0]), .ci(carry), .s(s), .co(co));

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      sha    <= '0;
      shb    <= '0;
      shr    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          sha   <= bus.a;
          shb   <= bus.b;
          carry <= bus.cin;
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          carry <= co;
          shr   <= {s, shr[WIDTH-1:1]};
          sha   <= sha >> 1;
          shb   <= shb >> 1;
          cnt   <= cnt + CW'(1);
          // last bit: publish the assembled word straight from the cell output
          if (cnt == CW'(WIDTH-1)) begin
            sum_q  <= {s, shr[WIDTH-1:1]};
            cout_q <= co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q  <= carry ^ co;
`endif
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();
  serial_adder #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from start; optional stray start raised after edge inj_k.
  // k counts edges after the accepted start edge; done is expected after edge WIDTH.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2, input logic tci,
                        input int inj_k, output int done_k, output int busy_n,
                        output int ndone, output int hold_bad);
    logic [7:0] prev;
    @(negedge clk);
    prev = bus.sum;
    bus.start = 1'b1; bus.a = ta; bus.b = tb2; bus.cin = tci;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    done_k = -1; ndone = 0; hold_bad = 0;
    busy_n = bus.busy ? 1 : 0;
    for (int k = 1; k <= WIDTH + 4; k++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (k < WIDTH && bus.sum !== prev) hold_bad++;
      if (k == inj_k) begin
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    int dk, bn, nd, hb;
    int dpos[$];
    int hold5;
    bit seen;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'h00);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    reset = 1'b1;

    // 1: 0x0F + 0x01
    run_op(8'h0F, 8'h01, 1'b0, -1, dk, bn, nd, hb);
    chk("t1_done_edge", 32'(dk), 32'd8);
    chk("t1_busy_cyc",  32'(bn), 32'd8);
    chk("t1_ndone",     32'(nd), 32'd1);
    chk("t1_sum",  32'(bus.sum),  32'h10);
    chk("t1_cout", 32'(bus.cout), 32'd0);

    // 2: carry-out cases
    run_op(8'hFF, 8'h01, 1'b0, -1, dk, bn, nd, hb);
    chk("t2a_sum",  32'(bus.sum),  32'h00);
    chk("t2a_cout", 32'(bus.cout), 32'd1);
    run_op(8'hFF, 8'hFF, 1'b1, -1, dk, bn, nd, hb);
    chk("t2b_sum",  32'(bus.sum),  32'hFF);
    chk("t2b_cout", 32'(bus.cout), 32'd1);
    chk("t2b_hold", 32'(hb), 32'd0);

    // 3: stray start during RUN is ignored
    run_op(8'h12, 8'h34, 1'b0, 3, dk, bn, nd, hb);
    chk("t3_sum",   32'(bus.sum),  32'h46);
    chk("t3_cout",  32'(bus.cout), 32'd0);
    chk("t3_ndone", 32'(nd), 32'd1);
    chk("t3_hold",  32'(hb), 32'd0);

    // 4: reset mid-RUN aborts
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_sum",  32'(bus.sum),  32'h00);
    chk("t4_cout", 32'(bus.cout), 32'd0);
    seen = 1'b0;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    chk("t4_no_done", 32'(seen), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, -1, dk, bn, nd, hb);
    chk("t4_sum2", 32'(bus.sum), 32'h07);

    // 5: start held high -> back-to-back operations every WIDTH+2 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
    hold5 = 0;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (bus.done) dpos.push_back(k);
      if (dpos.size() > 0 && bus.sum !== 8'h02) hold5++;
    end
    bus.start = 1'b0;
    chk("t5_ndone", 32'(dpos.size()), 32'd3);
    if (dpos.size() >= 3) begin
      chk("t5_first", 32'(dpos[0]), 32'd9);
      chk("t5_gap1", 32'(dpos[1] - dpos[0]), 32'd10);
      chk("t5_gap2", 32'(dpos[2] - dpos[1]), 32'd10);
    end
    chk("t5_sum_hold", 32'(hold5), 32'd0);
    repeat (WIDTH + 4) @(posedge clk);

`ifdef SERIAL_ADDER_OVF_EN
    // 6: signed overflow flag
    run_op(8'h7F, 8'h01, 1'b0, -1, dk, bn, nd, hb);
    chk("t6a_sum",  32'(bus.sum),  32'h80);
    chk("t6a_cout", 32'(bus.cout), 32'd0);
    chk("t6a_ovf",  32'(bus.ovf),  32'd1);
    run_op(8'h80, 8'h80, 1'b0, -1, dk, bn, nd, hb);
    chk("t6b_sum",  32'(bus.sum),  32'h00);
    chk("t6b_cout", 32'(bus.cout), 32'd1);
    chk("t6b_ovf",  32'(bus.ovf),  32'd1);
    run_op(8'h05, 8'h03, 1'b0, -1, dk, bn, nd, hb);
    chk("t6c_sum",  32'(bus.sum),  32'h08);
    chk("t6c_ovf",  32'(bus.ovf),  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
